// File: rtl/pad_stream_pkg.sv
`default_nettype none
// pad_stream_pkg -- shared FSM encoding, beat tag and geometry helpers for pad_stream_gen; rev 1.0
package pad_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic is_pad;
    logic sol;
    logic last;
  } tag_t;

  function automatic int padded_dim(input int dim, input int pad);
    return dim + 2 * pad;
  endfunction

  function automatic int total_tokens(input int w, input int h, input int pad);
    return padded_dim(w, pad) * padded_dim(h, pad);
  endfunction

  localparam int DEF_PAD_W  = padded_dim(224, 1);
  localparam int DEF_PAD_H  = padded_dim(224, 1);
  localparam int DEF_TOKENS = total_tokens(224, 224, 1);

endpackage
`default_nettype wire

// File: rtl/pad_skid_fifo.sv
`default_nettype none
// pad_skid_fifo -- synchronous power-of-2 FIFO with an occupancy count; rev 1.0
module pad_skid_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/pad_stream_gen.sv
`default_nettype none
// pad_stream_gen -- zero-bordered raster stream from an unpadded image RAM; rev 1.0
// Define PAD_STALL_CNT_EN to add the 32-bit stall_cnt output.
module pad_stream_gen
  import pad_stream_pkg::*;
#(
  parameter int IMG_W      = 224,
  parameter int IMG_H      = 224,
  parameter int PAD        = 1,
  parameter int DW         = 9,
  parameter int CH         = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_addr,
  input  logic [CH*DW-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic             out_sol,
  output logic             out_last
`ifdef PAD_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);
  localparam int PW     = padded_dim(IMG_W, PAD);
  localparam int PH     = padded_dim(IMG_H, PAD);
  localparam int CW     = $clog2(PW);
  localparam int RW     = $clog2(PH);
  localparam int DATA_W = CH * DW;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  state_t            state_nx;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [AW-1:0]     addr;
  logic              stage_valid;
  tag_t              stage_tag;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              issue;
  logic              interior;
  logic              col_last;
  logic              row_last;
  logic              last_tok;
  logic              pop;
  logic              fifo_empty;
  logic [DATA_W+1:0] push_data;
  logic [DATA_W+1:0] head;

  // The in-flight stage counts against FIFO space so a read can never land in a full FIFO.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, stage_valid};
  assign issue       = (state == ST_ISSUE) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign col_last    = (col == CW'(PW - 1));
  assign row_last    = (row == RW'(PH - 1));
  assign last_tok    = col_last && row_last;
  assign interior    = (row >= RW'(PAD)) && (row < RW'(PAD + IMG_H)) &&
                       (col >= CW'(PAD)) && (col < CW'(PAD + IMG_W));

  assign mem_ren  = issue && interior;
  assign mem_addr = addr;
  assign busy     = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done     = (state == ST_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      row         <= '0;
      col         <= '0;
      addr        <= '0;
      stage_valid <= 1'b0;
      stage_tag   <= '0;
    end else begin
      state       <= state_nx;
      stage_valid <= issue;
      if (issue) begin
        stage_tag.is_pad <= !interior;
        stage_tag.sol    <= (col == '0);
        stage_tag.last   <= last_tok;
      end
      if ((state == ST_IDLE) && start) begin
        row  <= '0;
        col  <= '0;
        addr <= '0;
      end else if (issue) begin
        // Interior positions are visited in raster order, so their addresses are consecutive.
        if (interior) addr <= addr + AW'(1);
        if (col_last) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_ISSUE;
      ST_ISSUE: if (issue && last_tok) state_nx = ST_DRAIN;
      ST_DRAIN: if (!stage_valid &&
                    ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop)))
                  state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign push_data = {stage_tag.sol, stage_tag.last,
                      stage_tag.is_pad ? {DATA_W{1'b0}} : mem_rdata};
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  pad_skid_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (stage_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign out_data = out_valid ? head[DATA_W-1:0] : {DATA_W{1'b0}};
  assign out_last = out_valid && head[DATA_W];
  assign out_sol  = out_valid && head[DATA_W+1];

`ifdef PAD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || ((state == ST_IDLE) && start)) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_pad_stream_gen.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pad_stream_gen -- scoreboard bench: small 4x3 frame variants plus one default-size frame.
module tb_pad_stream_gen;
  localparam int W      = 4;
  localparam int H      = 3;
  localparam int DWP    = 9;
  localparam int CHP    = 4;
  localparam int DEPTH  = 4;
  localparam int AWP    = 16;
  localparam int PW     = W + 2;
  localparam int NTOK   = PW * (H + 2);
  localparam int DATA_W = CHP * DWP;
  localparam int BW     = 224;
  localparam int BH     = 224;
  localparam int BPW    = BW + 2;
  localparam int BNTOK  = BPW * (BH + 2);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sol;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              busy, done, mem_ren, out_valid, out_sol, out_last;
  logic              out_ready = 1'b1;
  logic [AWP-1:0]    mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] out_data;

  logic              b_start = 1'b0;
  logic              b_busy, b_done, b_mem_ren, b_out_valid, b_out_sol, b_out_last;
  logic              b_out_ready = 1'b1;
  logic [AWP-1:0]    b_mem_addr;
  logic [DATA_W-1:0] b_mem_rdata = '0;
  logic [DATA_W-1:0] b_out_data;
`ifdef PAD_STALL_CNT_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       b_stall_cnt;
`endif

  pad_stream_gen #(
    .IMG_W(W), .IMG_H(H), .PAD(1), .DW(DWP), .CH(CHP), .FIFO_DEPTH(DEPTH), .AW(AWP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sol(out_sol), .out_last(out_last)
`ifdef PAD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pad_stream_gen dut_big (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_ren(b_mem_ren), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sol(b_out_sol), .out_last(b_out_last)
`ifdef PAD_STALL_CNT_EN
    , .stall_cnt(b_stall_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] word(input int a);
    logic [DWP-1:0] v;
    v = DWP'(a + 1);
    return {CHP{v}};
  endfunction

  // Synchronous RAM models: data one cycle after the read enable.
  always @(posedge clk) if (mem_ren)   mem_rdata   <= word(int'(mem_addr));
  always @(posedge clk) if (b_mem_ren) b_mem_rdata <= word(int'(b_mem_addr));

  function automatic beat_t exp_beat(input int i, input int pw, input int w, input int h);
    int r, c;
    beat_t b;
    r = i / pw;
    c = i % pw;
    b.data = '0;
    if (r >= 1 && r <= h && c >= 1 && c <= w) b.data = word((r - 1) * w + (c - 1));
    b.sol  = (c == 0);
    b.last = (i == pw * (h + 2) - 1);
    return b;
  endfunction

  int    n_pass = 0;
  int    n_total = 0;
  int    credit_viol = 0;
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_mem_ren"},   mem_ren, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_out_sol"},   out_sol, 0);
    chk({tag, "_out_last"},  out_last, 0);
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 7 valid cycles then high.
  task automatic run_frame(input int mode, input int abort_at, input bit poke_start);
    int    cyc = 0, beats = 0, first_valid = -1, bubbles = 0, stall_left = 7;
    bit    stalled = 1'b0, seen_last = 1'b0, finished = 1'b0, aborted = 1'b0;
    beat_t held, got, e;
    held = '0;
    exp_q.delete();
    for (int i = 0; i < NTOK; i++) exp_q.push_back(exp_beat(i, PW, W, H));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy, 1);
    while (!finished) begin
      if (seen_last) begin
        chk("done_after_last", done, 1);
        chk("busy_low_with_done", busy, 0);
        finished = 1'b1;
      end else begin
        got = {out_data, out_sol, out_last};
        if (out_valid && first_valid < 0) begin
          first_valid = cyc;
          if (mode == 0) chk("first_valid_latency", cyc - 1, 2);
        end
        if (mode == 0 && first_valid >= 0 && !out_valid) bubbles++;
        if (stalled) chk("stall_hold", {out_valid, got}, {1'b1, held});
        if (done) chk("premature_done", done, 0);
        if (mem_ren && (int'(dut.fifo_count) + int'(dut.stage_valid) >= DEPTH)) credit_viol++;
        if (abort_at >= 0 && beats == abort_at) begin
          aborted  = 1'b1;
          finished = 1'b1;
        end else begin
          case (mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2: begin
              out_ready = !(out_valid && stall_left > 0);
              if (!out_ready) stall_left--;
            end
            default: out_ready = 1'b1;
          endcase
          start = poke_start && (cyc == 10);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("extra_beat", beats, NTOK - 1);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("beat%0d", beats), got, e);
            end
            seen_last = out_last;
            beats++;
          end
          stalled = out_valid && !out_ready;
          held    = got;
        end
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
        if (cyc > 2000) begin
          chk("frame_timeout", cyc, 0);
          finished = 1'b1;
          aborted  = 1'b1;
        end
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (!aborted) begin
      chk("beat_count", beats, NTOK);
      if (mode == 0) chk("no_bubbles", bubbles, 0);
    end
  endtask

  initial begin
    int extra, cyc, first, idx, bubbles, ren_cnt, sol_err, data_err;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, -1, 1'b0);
    run_frame(1, -1, 1'b0);

    run_frame(0, 13, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midframe_reset");
    rst = 1'b0;
    run_frame(0, -1, 1'b0);

    run_frame(0, -1, 1'b1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("start_while_busy_ignored", extra, 0);

    run_frame(2, -1, 1'b0);
`ifdef PAD_STALL_CNT_EN
    chk("stall_cnt_at_done", stall_cnt, 7);
`endif
    chk("credit_violations", credit_viol, 0);

    // Default-size frame with the consumer always ready.
    first = -1; idx = 0; bubbles = 0; ren_cnt = 0; sol_err = 0; data_err = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 1;
    while (!b_done && cyc < 60000) begin
      if (b_mem_ren) ren_cnt++;
      if (b_out_valid) begin
        if (first < 0) first = cyc;
        if ({b_out_data, b_out_sol, b_out_last} !== exp_beat(idx, BPW, BW, BH)) data_err++;
        if (b_out_sol !== (idx % BPW == 0)) sol_err++;
        idx++;
      end else if (first >= 0 && idx < BNTOK) begin
        bubbles++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("big_done_seen", b_done, 1);
    chk("big_first_valid_latency", first - 1, 2);
    chk("big_beat_count", idx, BNTOK);
    chk("big_bubbles", bubbles, 0);
    chk("big_mem_ren_count", ren_cnt, BW * BH);
    chk("big_sol_errors", sol_err, 0);
    chk("big_data_errors", data_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pad_stream_gen.md
Name: pad_stream_gen

Overview:
- Producer side of the padded-pixel stream that the 3x3 conv line buffers consume.
- Reads an unpadded IMG_W x IMG_H feature map from a synchronous image RAM, CH channels in parallel.
- Emits the (IMG_W+2*PAD) x (IMG_H+2*PAD) raster stream with a zero border, one padded position per accepted beat, in row-major order.
- Sits between the image/feature RAM and the conv engine; one frame per start pulse.

Parameters:
- IMG_W, 224, unpadded width in pixels
- IMG_H, 224, unpadded height in pixels
- PAD, 1, border width (zeros) on each side
- DW, 9, bits per channel sample (signed, matches line buffer width)
- CH, 4, channels emitted in parallel
- FIFO_DEPTH, 4, output skid FIFO entries (power of 2, >=2)
- AW, 16, RAM address width (must cover IMG_W*IMG_H-1)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last beat is accepted
- mem_ren  out  1  RAM read enable
- mem_addr  out  AW  RAM address = y*IMG_W + x (unpadded coords)
- mem_rdata  in  CH*DW  RAM data, valid exactly 1 cycle after mem_ren; channel 0 in LSBs
- out_valid  out  1  stream beat valid
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready
- out_data  out  CH*DW  padded sample per channel, channel 0 in LSBs
- out_sol  out  1  first column of a padded row
- out_last  out  1  final beat of the frame

Behaviour:
- Reset values: busy=0, done=0, mem_ren=0, mem_addr=0, out_valid=0, out_data=0, out_sol=0, out_last=0.
- Reset applies in any state: FSM returns to IDLE, counters clear, FIFO empties, and any in-flight read is discarded.
- FSM states:
  - IDLE: on start go to ISSUE. start is ignored in all other states.
  - ISSUE: walk positions until the last token is issued, then go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to FIN.
  - FIN: pulse done for one cycle, then go to IDLE.
- Position counters: row and col over 0..IMG_H+2*PAD-1 and 0..IMG_W+2*PAD-1.
  - col wraps to 0 and increments row.
  - The frame is exactly (IMG_W+2*PAD)*(IMG_H+2*PAD) tokens; default 51076.
- Issue rule: a token is issued in a cycle iff state==ISSUE and (fifo_count + inflight) < FIFO_DEPTH. inflight is at most 1.
- Interior test: a position is interior iff PAD<=row<PAD+IMG_H and PAD<=col<PAD+IMG_W.
  - Interior tokens assert mem_ren with mem_addr=(row-PAD)*IMG_W+(col-PAD). The address is maintained incrementally, with no multiplier.
  - Border tokens keep mem_ren=0.
- Every token, interior or border, passes through one pipeline stage carrying {is_pad, sol, last}, so ordering is preserved.
- FIFO push data: mem_rdata for interior tokens, all zeros for pad tokens.
- Latency: the first out_valid occurs 2 cycles after start is accepted.
- Throughput: with out_ready held high and FIFO_DEPTH>=4, one beat per cycle with no bubbles, including across border/interior transitions.
- Backpressure: a stalled beat holds out_data, out_sol and out_last stable until accepted. The FIFO never overflows, because the credit rule counts the in-flight read.
- FIFO full and empty are derived from a count register of width $clog2(FIFO_DEPTH)+1. Pushing and popping in the same cycle leaves the count unchanged.
- out_last is asserted only on the beat at row=IMG_H+2*PAD-1, col=IMG_W+2*PAD-1.
- done rises the cycle after that beat is accepted; busy falls in the same cycle done rises.

Optional Feature:
- Macro: PAD_STALL_CNT_EN.
- Defined: adds output port stall_cnt (32 bits).
  - Cleared on rst and on accepted start.
  - Increments each cycle out_valid && !out_ready, saturating at all-ones.
  - Holds its value after done.
- Undefined: no port and no counter logic; the rest of the behaviour is identical.

Decomposition:
- Shared package pad_stream_pkg holds:
  - FSM state encoding (IDLE, ISSUE, DRAIN, FIN)
  - the tag struct {is_pad, sol, last}
  - localparams for padded width/height and total tokens as functions of the parameters
- One natural sub-module, pad_skid_fifo: a synchronous FIFO of width CH*DW+2 and depth FIFO_DEPTH, exposing count.

Test Plan:
- IMG_W=4, IMG_H=3, PAD=1, RAM word = address+1 per channel, out_ready=1 -> exactly 30 beats.
  - Beats 0-5, 24-29, and each col 0/5 are zero.
  - Beat 7 = word 1, beat 22 = word 12.
  - out_last only on beat 29; done 1 cycle later.
- Same config with out_ready toggling pseudo-randomly -> identical beat sequence.
  - Data is stable while stalled.
  - No RAM read is issued while fifo_count+inflight==FIFO_DEPTH.
- Default parameters with out_ready=1 -> 51076 beats in 51076 consecutive cycles after the 2-cycle latency.
  - out_sol every 226 beats.
  - mem_ren asserted exactly 50176 times.
- rst asserted mid-frame (beat 13 of the small config) -> all outputs return to reset values the next cycle.
  - A new start yields a complete, correct 30-beat frame.
- start pulsed while busy -> ignored; exactly one done pulse per accepted start.
- With PAD_STALL_CNT_EN defined, out_ready low for 7 cycles while valid -> stall_cnt=7 at done.
